// File: rtl/traffic_phase_ctrl_if.sv
// Timer handshake between the phase sequencer (master) and the countdown timer (slave).
interface traffic_phase_ctrl_if;
  logic       start_t;
  logic [3:0] tp_val;
  logic       expired;

  modport master (output start_t, output tp_val, input expired);
  modport slave  (input start_t, input tp_val, output expired);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road main/side traffic phase sequencer driving an external countdown timer.
// Optional pedestrian walk phase is built in when TRAFFIC_WALK_EN is defined.
module traffic_phase_ctrl #(
  parameter int unsigned T_MAIN_GRN = 8,
  parameter int unsigned T_SIDE_GRN = 5,
  parameter int unsigned T_EXT      = 3,
  parameter int unsigned T_YEL      = 2,
  parameter int unsigned T_RED      = 1,
  parameter int unsigned T_WALK     = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 side_car,
  input  logic                 walk_req,
  traffic_phase_ctrl_if.master tmr,
  output logic [2:0]           main_lights,
  output logic [2:0]           side_lights,
  output logic                 walk,
  output logic [2:0]           state_dbg
);

  if (T_MAIN_GRN > 15 || T_SIDE_GRN > 15 || T_EXT > 15 ||
      T_YEL > 15 || T_RED > 15 || T_WALK > 15) begin : g_bad_duration
    $error("traffic_phase_ctrl: phase durations must fit in 4 bits");
  end

  // A zero duration would never expire on the timer, so it is promoted to one tick.
  function automatic logic [3:0] dur(input int unsigned t);
    return (t == 0) ? 4'd1 : t[3:0];
  endfunction

  localparam logic [3:0] D_MAIN = dur(T_MAIN_GRN);
  localparam logic [3:0] D_SIDE = dur(T_SIDE_GRN);
  localparam logic [3:0] D_EXT  = dur(T_EXT);
  localparam logic [3:0] D_YEL  = dur(T_YEL);
  localparam logic [3:0] D_RED  = dur(T_RED);

  typedef enum logic [2:0] {
    MAIN_GRN    = 3'd0,
    MAIN_YEL    = 3'd1,
    RED_TO_SIDE = 3'd2,
    SIDE_GRN    = 3'd3,
    SIDE_YEL    = 3'd4,
    RED_TO_MAIN = 3'd5,
    WALK        = 3'd6
  } state_t;

  function automatic logic [2:0] main_of(input state_t s);
    return (s == MAIN_GRN) ? 3'b001 : (s == MAIN_YEL) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] side_of(input state_t s);
    return (s == SIDE_GRN) ? 3'b001 : (s == SIDE_YEL) ? 3'b010 : 3'b100;
  endfunction

  state_t     state, nxt;
  logic       boot, armed, start_q;
  logic [3:0] tp_q, nxt_tp;
  logic       go, qual, sg_entry;
  logic       side_s1, side_s2, side_pend, ext_used;

`ifdef TRAFFIC_WALK_EN
  localparam logic [3:0] D_WALK = dur(T_WALK);
  logic walk_s1, walk_s2, walk_pend, walk_to_side;
`else
  localparam int unsigned unused_t_walk = T_WALK;
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign walk            = 1'b0;
`endif

  assign qual      = armed && !start_q && tmr.expired;
  assign sg_entry  = go && (nxt == SIDE_GRN) && (state != SIDE_GRN);
  assign state_dbg = state;
  assign tmr.start_t = start_q;
  assign tmr.tp_val  = tp_q;

  always_comb begin
    go     = 1'b0;
    nxt    = state;
    nxt_tp = tp_q;
    if (boot) begin
      go = 1'b1; nxt = RED_TO_MAIN; nxt_tp = D_RED;
    end else if (qual) begin
      case (state)
        // Without demand, MAIN_GRN parks with expired still high so the
        // first cycle a pend becomes visible moves on immediately.
        MAIN_GRN: if (side_pend || side_s2) begin
          go = 1'b1; nxt = MAIN_YEL; nxt_tp = D_YEL;
        end
        MAIN_YEL: begin go = 1'b1; nxt = RED_TO_SIDE; nxt_tp = D_RED; end
        RED_TO_SIDE: begin
          go = 1'b1; nxt = SIDE_GRN; nxt_tp = D_SIDE;
`ifdef TRAFFIC_WALK_EN
          if (walk_pend) begin nxt = WALK; nxt_tp = D_WALK; end
`endif
        end
        SIDE_GRN: begin
          go = 1'b1;
          if (side_s2 && !ext_used) begin nxt = SIDE_GRN; nxt_tp = D_EXT; end
          else begin nxt = SIDE_YEL; nxt_tp = D_YEL; end
        end
        SIDE_YEL: begin go = 1'b1; nxt = RED_TO_MAIN; nxt_tp = D_RED; end
        RED_TO_MAIN: begin
          go = 1'b1; nxt = MAIN_GRN; nxt_tp = D_MAIN;
`ifdef TRAFFIC_WALK_EN
          if (walk_pend) begin nxt = WALK; nxt_tp = D_WALK; end
`endif
        end
`ifdef TRAFFIC_WALK_EN
        WALK: begin
          go = 1'b1;
          if (walk_to_side) begin nxt = SIDE_GRN; nxt_tp = D_SIDE; end
          else begin nxt = MAIN_GRN; nxt_tp = D_MAIN; end
        end
`endif
        default: begin go = 1'b1; nxt = RED_TO_MAIN; nxt_tp = D_RED; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RED_TO_MAIN;
      boot        <= 1'b1;
      armed       <= 1'b0;
      start_q     <= 1'b0;
      tp_q        <= D_RED;
      main_lights <= 3'b100;
      side_lights <= 3'b100;
      side_s1     <= 1'b0;
      side_s2     <= 1'b0;
      side_pend   <= 1'b0;
      ext_used    <= 1'b0;
`ifdef TRAFFIC_WALK_EN
      walk_s1      <= 1'b0;
      walk_s2      <= 1'b0;
      walk_pend    <= 1'b0;
      walk_to_side <= 1'b0;
      walk         <= 1'b0;
`endif
    end else begin
      side_s1 <= side_car;
      side_s2 <= side_s1;
      boot    <= 1'b0;
      start_q <= go;
      armed   <= !go;
      if (sg_entry)     side_pend <= 1'b0;
      else if (side_s2) side_pend <= 1'b1;
      if (go && nxt == SIDE_GRN) ext_used <= (state == SIDE_GRN);
      if (go) begin
        state       <= nxt;
        tp_q        <= nxt_tp;
        main_lights <= main_of(nxt);
        side_lights <= side_of(nxt);
      end
`ifdef TRAFFIC_WALK_EN
      walk_s1 <= walk_req;
      walk_s2 <= walk_s1;
      if (go && nxt == WALK) walk_pend <= 1'b0;
      else if (walk_s2)      walk_pend <= 1'b1;
      if (go && nxt == WALK) walk_to_side <= (state == RED_TO_SIDE);
      if (go)                walk <= (nxt == WALK);
`endif
    end
  end

endmodule
